// File: rtl/param_count_fsm.sv
// Tick-paced up/down counter controlled by a three-state FSM (IDLE/COUNT/PAUSE).
// A free-running divider strobes tick once every DIV_MAX+1 clocks; the counter steps only on tick.
module param_count_fsm #(
    parameter int WIDTH   = 4,
    parameter int DIV_MAX = 1500000,
    parameter int DIV_W   = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    input  logic             abort,
    input  logic             pause,
    input  logic             dir,
    input  logic             cont,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             tick
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        COUNT = 2'b01,
        PAUSE = 2'b10
    } state_t;

    localparam logic [DIV_W-1:0] DIV_END = DIV_W'(DIV_MAX);

    state_t           state;
    state_t           state_nxt;
    logic [DIV_W-1:0] div_cnt;
    logic             dir_q;
    logic [WIDTH-1:0] limit_q;
    logic [WIDTH-1:0] count_nxt;
    logic             done_nxt;
    logic [WIDTH-1:0] end_val;
    logic [WIDTH-1:0] start_val;
    logic             at_end;

    function automatic logic [WIDTH-1:0] step_count(input logic [WIDTH-1:0] v,
                                                    input logic down);
        return down ? (v - WIDTH'(1)) : (v + WIDTH'(1));
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (div_cnt == DIV_END) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    assign tick = (div_cnt == DIV_END);

    // Run parameters are captured only when a go is accepted and held for the whole run.
    always_ff @(posedge clk) begin
        if (state == IDLE && go && !abort) begin
            dir_q   <= dir;
            limit_q <= limit;
        end
    end

    assign end_val   = dir_q ? '0 : limit_q;
    assign start_val = dir_q ? limit_q : '0;
    assign at_end    = (count == end_val);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (go) state_nxt = COUNT;
                COUNT: begin
                    if (pause)                      state_nxt = PAUSE;
                    else if (tick && at_end && !cont) state_nxt = IDLE;
                end
                PAUSE:   if (!pause) state_nxt = COUNT;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Pause wins over a coincident tick: the end value is compared before any step.
    always_comb begin
        count_nxt = count;
        done_nxt  = 1'b0;
        if (abort) begin
            count_nxt = '0;
        end else begin
            case (state)
                IDLE: if (go) count_nxt = dir ? limit : '0;
                COUNT: begin
                    if (!pause && tick) begin
                        if (at_end) begin
                            done_nxt = 1'b1;
                            if (cont) count_nxt = start_val;
                        end else begin
                            count_nxt = step_count(count, dir_q);
                        end
                    end
                end
                default: count_nxt = count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            done  <= 1'b0;
            busy  <= 1'b0;
        end else begin
            count <= count_nxt;
            done  <= done_nxt;
            busy  <= (state_nxt == COUNT) || (state_nxt == PAUSE);
        end
    end

endmodule

// File: tb/tb_param_count_fsm.sv
// Bench for param_count_fsm: directed scenarios plus random stimulus, all checked
// cycle by cycle against a behavioural model of the counter rules.
module tb_param_count_fsm;

    localparam int WIDTH   = 4;
    localparam int DIV_MAX = 3;
    localparam int DIV_W   = 4;

    logic             clk;
    logic             rst;
    logic             go;
    logic             abort;
    logic             pause;
    logic             dir;
    logic             cont;
    logic [WIDTH-1:0] limit;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             done;
    logic             tick;

    int n_tests;
    int n_fail;
    int ndone;

    // Model: mode 0 = idle, 1 = running, 2 = paused; m_div = clocks since reset mod (DIV_MAX+1)
    int m_mode;
    int m_div;
    int m_count;
    int m_lim;
    bit m_dir;
    bit m_done;

    param_count_fsm #(.WIDTH(WIDTH), .DIV_MAX(DIV_MAX), .DIV_W(DIV_W)) dut (
        .clk(clk), .rst(rst), .go(go), .abort(abort), .pause(pause), .dir(dir),
        .cont(cont), .limit(limit), .count(count), .busy(busy), .done(done), .tick(tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode  = 0;
        m_div   = 0;
        m_count = 0;
        m_done  = 1'b0;
    endtask

    task automatic model_update();
        bit t;
        int target;
        t      = (m_div == DIV_MAX);
        m_done = 1'b0;
        if (abort) begin
            m_mode  = 0;
            m_count = 0;
        end else if (m_mode == 0) begin
            if (go) begin
                m_dir   = dir;
                m_lim   = int'(limit);
                m_count = dir ? int'(limit) : 0;
                m_mode  = 1;
            end
        end else if (m_mode == 2) begin
            if (!pause) m_mode = 1;
        end else if (pause) begin
            m_mode = 2;
        end else if (t) begin
            target = m_dir ? 0 : m_lim;
            if (m_count == target) begin
                m_done = 1'b1;
                if (cont) m_count = m_dir ? m_lim : 0;
                else      m_mode  = 0;
            end else begin
                m_count = m_dir ? m_count - 1 : m_count + 1;
            end
        end
        m_div = (m_div + 1) % (DIV_MAX + 1);
    endtask

    task automatic step_clk();
        model_update();
        @(posedge clk);
        #1;
        chk("count", int'(count), m_count);
        chk("busy",  int'(busy),  (m_mode != 0) ? 1 : 0);
        chk("done",  int'(done),  int'(m_done));
        chk("tick",  int'(tick),  (m_div == DIV_MAX) ? 1 : 0);
        if (done) ndone++;
    endtask

    task automatic start_run(input bit d, input int lim, input bit c);
        dir   = d;
        limit = WIDTH'(lim);
        cont  = c;
        go    = 1'b1;
        step_clk();
        go    = 1'b0;
    endtask

    initial begin
        int seq[$];
        int prev;
        int busy_low;

        n_tests = 0;
        n_fail  = 0;
        ndone   = 0;
        rst = 1'b1; go = 1'b0; abort = 1'b0; pause = 1'b0;
        dir = 1'b0; cont = 1'b0; limit = '0;
        m_lim = 0; m_dir = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", int'(count), 0);
        chk("rst_busy",  int'(busy), 0);
        chk("rst_done",  int'(done), 0);
        chk("rst_tick",  int'(tick), 0);
        rst = 1'b0;

        // Up single run to 5
        ndone = 0;
        start_run(1'b0, 5, 1'b0);
        for (int i = 0; i < 60 && busy; i++) step_clk();
        chk("up_idle", int'(busy), 0);
        chk("up_final", int'(count), 5);
        chk("up_dones", ndone, 1);

        // Down auto-reload from 3
        seq.delete();
        prev = int'(count);
        busy_low = 0;
        start_run(1'b1, 3, 1'b1);
        if (int'(count) != prev) begin seq.push_back(int'(count)); prev = int'(count); end
        for (int i = 0; i < 40; i++) begin
            step_clk();
            if (!busy) busy_low++;
            if (int'(count) != prev) begin seq.push_back(int'(count)); prev = int'(count); end
        end
        chk("reload_len", (seq.size() >= 8) ? 1 : 0, 1);
        for (int i = 0; i < 8 && i < seq.size(); i++) chk("reload_seq", seq[i], 3 - (i % 4));
        chk("reload_busy_low", busy_low, 0);
        abort = 1'b1;
        step_clk();
        abort = 1'b0;
        chk("abort_idle", int'(busy), 0);

        // Pause for 10 clocks at count 2
        start_run(1'b0, 9, 1'b0);
        for (int i = 0; i < 60 && count != 2; i++) step_clk();
        chk("pause_reach2", int'(count), 2);
        pause = 1'b1;
        repeat (10) step_clk();
        chk("pause_hold", int'(count), 2);
        pause = 1'b0;
        for (int i = 0; i < 20 && count == 2; i++) step_clk();
        chk("pause_resume", int'(count), 3);
        abort = 1'b1;
        step_clk();
        abort = 1'b0;

        // Abort coinciding with the terminal tick
        start_run(1'b0, 1, 1'b0);
        for (int i = 0; i < 40 && !(count == 1 && tick); i++) step_clk();
        chk("abt_terminal_seen", int'(count == 1 && tick), 1);
        ndone = 0;
        abort = 1'b1;
        step_clk();
        abort = 1'b0;
        chk("abt_count", int'(count), 0);
        chk("abt_busy", int'(busy), 0);
        step_clk();
        chk("abt_no_done", ndone, 0);

        // limit 0, counting up
        ndone = 0;
        start_run(1'b0, 0, 1'b0);
        for (int i = 0; i < 20 && busy; i++) step_clk();
        chk("lim0_idle", int'(busy), 0);
        chk("lim0_count", int'(count), 0);
        chk("lim0_dones", ndone, 1);

        // Asynchronous reset mid-run at count 7
        start_run(1'b0, 15, 1'b0);
        for (int i = 0; i < 60 && count != 7; i++) step_clk();
        chk("rst_reach7", int'(count), 7);
        rst = 1'b1;
        #1;
        model_reset();
        chk("arst_count", int'(count), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_tick", int'(tick), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        ndone = 0;
        repeat (40) step_clk();
        chk("arst_no_done", ndone, 0);

        // Random stimulus
        for (int i = 0; i < 1500; i++) begin
            go    = ($urandom % 4) == 0;
            abort = ($urandom % 40) == 0;
            if (($urandom % 6) == 0) pause = ~pause;
            dir   = $urandom % 2;
            cont  = $urandom % 2;
            limit = WIDTH'($urandom % 16);
            step_clk();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
